// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared types and round-robin pick for the serial compare scheduler
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic less;
        logic eq;
        logic greater;
    } cmp_result_t;

    localparam int unsigned MAX_NREQ = 32;

    // First valid index at or after ptr, wrapping modulo nreq; 0 when nothing is valid.
    function automatic int unsigned rr_pick(input logic [MAX_NREQ-1:0] valid,
                                            input int unsigned         ptr,
                                            input int unsigned         nreq);
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            idx = ptr + k;
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if (k < nreq && !found && valid[idx[4:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/serial_cmp_msb_core.sv
// rtl/serial_cmp_msb_core.sv - MSB-first bit-serial magnitude compare state (eq/less)
module serial_cmp_msb_core
    import serial_cmp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic a_bit,
    input  logic b_bit,
    output logic less,
    output logic eq,
    output logic greater
);

    logic eq_q, eq_d;
    logic less_q, less_d;

    // The first differing bit decides; later bits cannot change a frozen decision.
    always_comb begin
        eq_d   = eq_q;
        less_d = less_q;
        if (clr) begin
            eq_d   = 1'b1;
            less_d = 1'b0;
        end else if (en && eq_q && (a_bit != b_bit)) begin
            eq_d   = 1'b0;
            less_d = b_bit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eq_q   <= 1'b1;
            less_q <= 1'b0;
        end else begin
            eq_q   <= eq_d;
            less_q <= less_d;
        end
    end

    assign less    = less_q;
    assign eq      = eq_q;
    assign greater = ~eq_q & ~less_q;

endmodule

// File: rtl/serial_cmp_scheduler.sv
// rtl/serial_cmp_scheduler.sv - round-robin sharing of one bit-serial comparator among NREQ clients
module serial_cmp_scheduler
    import serial_cmp_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 3,
    localparam int IDW   = $clog2(NREQ > 1 ? NREQ : 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_less,
    output logic                  rsp_eq,
    output logic                  rsp_greater,
    output logic                  busy
);

    localparam int CW = $clog2(WIDTH + 1);

    sched_state_t     state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             core_clr, core_en;
    cmp_result_t      core_res, rsp_res;
    logic [IDW-1:0]   pick;

    assign pick = IDW'(rr_pick(MAX_NREQ'(req_valid), 32'(ptr_q), NREQ));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        cnt_d     = cnt_q;
        core_clr  = 1'b0;
        core_en   = 1'b0;
        req_ready = '0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = NREQ'(1) << pick;
                    grant_d   = pick;
                    a_sh_d    = req_a[32'(pick)*WIDTH +: WIDTH];
                    b_sh_d    = req_b[32'(pick)*WIDTH +: WIDTH];
                    cnt_d     = CW'(WIDTH);
                    core_clr  = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                core_en = 1'b1;
                a_sh_d  = a_sh_q << 1;
                b_sh_d  = b_sh_q << 1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
        end
    end

    serial_cmp_msb_core u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (core_clr),
        .en      (core_en),
        .a_bit   (a_sh_q[WIDTH-1]),
        .b_bit   (b_sh_q[WIDTH-1]),
        .less    (core_res.less),
        .eq      (core_res.eq),
        .greater (core_res.greater)
    );

    // Result and id are only meaningful while a response is offered.
    assign rsp_res     = rsp_valid ? core_res : '0;
    assign rsp_id      = rsp_valid ? grant_q : '0;
    assign rsp_less    = rsp_res.less;
    assign rsp_eq      = rsp_res.eq;
    assign rsp_greater = rsp_res.greater;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serial_cmp_scheduler.sv
// tb/tb_serial_cmp_scheduler.sv - directed self-checking bench for serial_cmp_scheduler
module tb_serial_cmp_scheduler;

    localparam int WIDTH = 8;
    localparam int NREQ  = 3;
    localparam int IDW   = 2;

    localparam logic [2:0] R_LT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_GT = 3'b001;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_less;
    logic                  rsp_eq;
    logic                  rsp_greater;
    logic                  busy;

    int n_cmp = 0;
    int n_bad = 0;

    serial_cmp_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_less    (rsp_less),
        .rsp_eq      (rsp_eq),
        .rsp_greater (rsp_greater),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_ready(input int exp_id, input string tag);
        int n;
        n = 0;
        while (req_ready == '0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_ready"}, 32'(req_ready), 32'(1) << exp_id);
    endtask

    // Accept edge, SHIFT, RESP (optionally stalled), handshake.
    task automatic finish_txn(input int exp_id, input logic [2:0] exp_res, input bit drop,
                              input int hold, input string tag);
        int lat;
        logic [2:0] res0;
        @(posedge clk);
        @(negedge clk); #1;
        if (drop) req_valid = '0;
        #1;
        chk({tag, "_busy_shift"}, 32'(busy), 32'd1);
        chk({tag, "_noready_shift"}, 32'(req_ready), 32'd0);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd9);
        chk({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        chk({tag, "_result"}, 32'({rsp_less, rsp_eq, rsp_greater}), 32'(exp_res));
        res0 = {rsp_less, rsp_eq, rsp_greater};
        if (hold > 0) begin
            req_valid = 3'b001;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk); #1;
                chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, "_hold_id"}, 32'(rsp_id), 32'(exp_id));
                chk({tag, "_hold_result"}, 32'({rsp_less, rsp_eq, rsp_greater}), 32'(res0));
                chk({tag, "_hold_noready"}, 32'(req_ready), 32'd0);
                chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
            end
            req_valid = '0;
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_dropped"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_gated"}, 32'({rsp_id, rsp_less, rsp_eq, rsp_greater}), 32'd0);
    endtask

    initial begin
        int seen;
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_less, rsp_eq, rsp_greater, busy}), 32'd0);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // Test 1: basic greater with latency
        set_ops(0, 8'h64, 8'h62); req_valid = 3'b001; #1;
        wait_ready(0, "t1");
        finish_txn(0, R_GT, 1'b1, 0, "t1");

        // Test 2: equal, then less
        set_ops(1, 8'h82, 8'h82); req_valid = 3'b010; #1;
        wait_ready(1, "t2a");
        finish_txn(1, R_EQ, 1'b1, 0, "t2a");
        set_ops(2, 8'h00, 8'hFF); req_valid = 3'b100; #1;
        wait_ready(2, "t2b");
        finish_txn(2, R_LT, 1'b1, 0, "t2b");

        // Test 3: MSB decides, LSB decides
        set_ops(0, 8'h80, 8'h7F); req_valid = 3'b001; #1;
        wait_ready(0, "t3a");
        finish_txn(0, R_GT, 1'b1, 0, "t3a");
        set_ops(2, 8'h02, 8'h03); req_valid = 3'b100; #1;
        wait_ready(2, "t3b");
        finish_txn(2, R_LT, 1'b1, 0, "t3b");

        // Test 4: all valid and held -> 0,1,2,0
        set_ops(0, 8'h10, 8'h20);
        set_ops(1, 8'h30, 8'h30);
        set_ops(2, 8'h50, 8'h40);
        req_valid = 3'b111; #1;
        wait_ready(0, "t4a");
        finish_txn(0, R_LT, 1'b0, 0, "t4a");
        wait_ready(1, "t4b");
        finish_txn(1, R_EQ, 1'b0, 0, "t4b");
        wait_ready(2, "t4c");
        finish_txn(2, R_GT, 1'b0, 0, "t4c");
        wait_ready(0, "t4d");
        finish_txn(0, R_LT, 1'b1, 0, "t4d");

        // Test 5: response back-pressure for 5 cycles
        set_ops(0, 8'hAA, 8'hAA);
        set_ops(1, 8'h05, 8'h09); req_valid = 3'b010; #1;
        wait_ready(1, "t5");
        finish_txn(1, R_LT, 1'b1, 5, "t5");

        // Test 6: reset mid-SHIFT discards req1
        set_ops(1, 8'hF0, 8'h0F); req_valid = 3'b010; #1;
        wait_ready(1, "t6");
        @(posedge clk);
        @(negedge clk); #1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("t6_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b0; #1;
        chk("t6_async_clear", 32'({req_ready, rsp_valid, rsp_id, rsp_less, rsp_eq, rsp_greater, busy}), 32'd0);
        @(negedge clk); #1;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (rsp_valid || busy) seen++;
        end
        chk("t6_no_stale_rsp", 32'(seen), 32'd0);
        set_ops(0, 8'h11, 8'h11);
        set_ops(2, 8'h01, 8'h00);
        req_valid = 3'b111; #1;
        wait_ready(0, "t6_next");
        finish_txn(0, R_EQ, 1'b1, 0, "t6_next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
